// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: widths, response codes and FSM states
// shared by the AXI4-Lite initiator and its bus interface.
package axi4lite_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRREQ,
        WRRSP,
        RDREQ,
        RDRSP,
        RESP
    } stateT;
endpackage

// File: rtl/axi4lite_master_if.sv
// axi4lite_master_if: the five AXI4-Lite channels between
// the initiator (master) and a register-block slave.
interface axi4lite_master_if;
    import axi4lite_pkg::*;

    logic [ADDR_W-1:0] oAWADDR;
    logic [2:0]        oAWPROT;
    logic              oAWVALID;
    logic              iAWREADY;
    logic [DATA_W-1:0] oWDATA;
    logic [3:0]        oWSTRB;
    logic              oWVALID;
    logic              iWREADY;
    logic [1:0]        iBRESP;
    logic              iBVALID;
    logic              oBREADY;
    logic [ADDR_W-1:0] oARADDR;
    logic [2:0]        oARPROT;
    logic              oARVALID;
    logic              iARREADY;
    logic [DATA_W-1:0] iRDATA;
    logic [1:0]        iRRESP;
    logic              iRVALID;
    logic              oRREADY;

    modport master (
        output oAWADDR, oAWPROT, oAWVALID,
        input  iAWREADY,
        output oWDATA, oWSTRB, oWVALID,
        input  iWREADY,
        input  iBRESP, iBVALID,
        output oBREADY,
        output oARADDR, oARPROT, oARVALID,
        input  iARREADY,
        input  iRDATA, iRRESP, iRVALID,
        output oRREADY
    );

    modport slave (
        input  oAWADDR, oAWPROT, oAWVALID,
        output iAWREADY,
        input  oWDATA, oWSTRB, oWVALID,
        output iWREADY,
        output iBRESP, iBVALID,
        input  oBREADY,
        input  oARADDR, oARPROT, oARVALID,
        output iARREADY,
        output iRDATA, iRRESP, iRVALID,
        input  oRREADY
    );
endinterface

// File: rtl/axi4lite_wdog.sv
// axi4lite_wdog: saturating per-transaction cycle counter
// with a sticky expired flag; TOUT = 0 disables it.
module axi4lite_wdog #(
    parameter int TOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int W = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
    localparam logic [W-1:0] LIM = W'(TOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run && cnt != LIM) begin
            cnt <= cnt + W'(1);
        end
    end

    // flag rises on the same edge the count reaches TOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            expired <= 1'b0;
        end else if (TOUT != 0 && run && cnt == LIM - W'(1)) begin
            expired <= 1'b1;
        end
    end
endmodule

// File: rtl/axi4lite_master.sv
// axi4lite_master: single-outstanding AXI4-Lite initiator
// bridging a command/response port onto the AXI channels.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter logic [2:0] PROT = 3'b000,
    parameter int          TOUT = 1024
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCMDVALID,
    output logic              oCMDREADY,
    input  logic              iCMDWR,
    input  logic [ADDR_W-1:0] iCMDADR,
    input  logic [DATA_W-1:0] iCMDWDAT,
    input  logic [3:0]        iCMDSTRB,
    output logic              oRSPVALID,
    input  logic              iRSPREADY,
    output logic              oRSPWR,
    output logic [DATA_W-1:0] oRSPRDAT,
    output logic [1:0]        oRSPRESP,
    output logic              oTOUT,
    axi4lite_master_if.master bus
);
    stateT             state;
    stateT             stateNxt;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rdat;
    logic [3:0]        strb;
    logic [1:0]        resp;
    logic              wr;
    logic              awPend;
    logic              wPend;
    logic              accept;
    logic              awDone;
    logic              wDone;

    assign oCMDREADY = (state == IDLE) && !iRST;
    assign accept    = (state == IDLE) && iCMDVALID;
    assign awDone    = !awPend || bus.iAWREADY;
    assign wDone     = !wPend || bus.iWREADY;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:    if (iCMDVALID) stateNxt = iCMDWR ? WRREQ : RDREQ;
            WRREQ:   if (awDone && wDone) stateNxt = WRRSP;
            WRRSP:   if (bus.iBVALID) stateNxt = RESP;
            RDREQ:   if (bus.iARREADY) stateNxt = RDRSP;
            RDRSP:   if (bus.iRVALID) stateNxt = RESP;
            RESP:    if (iRSPREADY) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // AW and W are tracked separately so either may finish first
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            adr    <= '0;
            wdat   <= '0;
            strb   <= '0;
            wr     <= 1'b0;
            rdat   <= '0;
            resp   <= OKAY;
            awPend <= 1'b0;
            wPend  <= 1'b0;
        end else begin
            if (accept) begin
                adr    <= {iCMDADR[ADDR_W-1:2], 2'b00};
                wdat   <= iCMDWDAT;
                strb   <= iCMDSTRB;
                wr     <= iCMDWR;
                rdat   <= '0;
                resp   <= OKAY;
                awPend <= iCMDWR;
                wPend  <= iCMDWR;
            end
            if (state == WRREQ) begin
                if (bus.iAWREADY) awPend <= 1'b0;
                if (bus.iWREADY) wPend <= 1'b0;
            end
            if (state == WRRSP && bus.iBVALID) begin
                resp <= bus.iBRESP;
            end
            if (state == RDRSP && bus.iRVALID) begin
                rdat <= bus.iRDATA;
                resp <= bus.iRRESP;
            end
        end
    end

    assign bus.oAWADDR  = adr;
    assign bus.oAWPROT  = PROT;
    assign bus.oAWVALID = (state == WRREQ) && awPend;
    assign bus.oWDATA   = wdat;
    assign bus.oWSTRB   = strb;
    assign bus.oWVALID  = (state == WRREQ) && wPend;
    assign bus.oBREADY  = (state == WRRSP);
    assign bus.oARADDR  = adr;
    assign bus.oARPROT  = PROT;
    assign bus.oARVALID = (state == RDREQ);
    assign bus.oRREADY  = (state == RDRSP);

    assign oRSPVALID = (state == RESP);
    assign oRSPWR    = wr;
    assign oRSPRDAT  = rdat;
    assign oRSPRESP  = resp;

    axi4lite_wdog #(
        .TOUT(TOUT)
    ) uWdog (
        .clk    (iCLK),
        .rst    (iRST),
        .clear  (accept),
        .run    (state != IDLE && state != RESP),
        .expired(oTOUT)
    );
endmodule

// File: tb/tb_axi4lite_master.sv
// tb_axi4lite_master: vector table, random transactions against a
// latency/data model, watchdog and mid-transaction reset sequences.
module tb_axi4lite_master;
    import axi4lite_pkg::*;

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        logic [31:0] sdat;
        logic [1:0]  sresp;
        int          d0;
        int          d1;
        int          d2;
        int          rspDly;
        logic [31:0] expAdr;
        logic [31:0] expRdat;
        logic [1:0]  expResp;
        int          expLat;
    } vecT;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid, cmdReady, cmdWr;
    logic [31:0] cmdAdr, cmdWdat;
    logic [3:0]  cmdStrb;
    logic        rspValid, rspReady, rspWr;
    logic [31:0] rspRdat;
    logic [1:0]  rspResp;
    logic        tout;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // slave configuration and observation
    int          awDly, wDly, bDly, arDly, rDly;
    int          awCnt, wCnt, bCnt, arCnt, rCnt, arCycles;
    logic [31:0] sData;
    logic [1:0]  sResp;
    logic        awDone, wDone, arDone;
    logic        awHs, wHs, arHs, bHs, rHs;
    logic        pAwV, pWV, pArV;
    logic [31:0] pAwAddr, pWData, pArAddr;
    logic [31:0] awCap, wCap, arCap;
    logic [3:0]  strbCap;

    axi4lite_master_if bus();

    axi4lite_master #(
        .PROT(3'b101),
        .TOUT(8)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iCMDVALID(cmdValid),
        .oCMDREADY(cmdReady),
        .iCMDWR   (cmdWr),
        .iCMDADR  (cmdAdr),
        .iCMDWDAT (cmdWdat),
        .iCMDSTRB (cmdStrb),
        .oRSPVALID(rspValid),
        .iRSPREADY(rspReady),
        .oRSPWR   (rspWr),
        .oRSPRDAT (rspRdat),
        .oRSPRESP (rspResp),
        .oTOUT    (tout),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic slaveClear();
        bus.iAWREADY = 0; bus.iWREADY = 0; bus.iARREADY = 0;
        bus.iBVALID = 0; bus.iBRESP = 0;
        bus.iRVALID = 0; bus.iRRESP = 0; bus.iRDATA = 0;
        awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
        awDone = 0; wDone = 0; arDone = 0;
        awHs = 0; wHs = 0; arHs = 0; bHs = 0; rHs = 0;
        pAwV = 0; pWV = 0; pArV = 0;
    endtask

    // slave model: readies/valids change on negedge only
    initial begin
        slaveClear();
        forever begin
            @(negedge clk);
            if (rst) begin
                slaveClear();
            end else begin
                if (awHs) awDone = 1;
                if (wHs) wDone = 1;
                if (arHs) arDone = 1;
                if (bHs) begin
                    bus.iBVALID = 0; awDone = 0; wDone = 0; bCnt = 0;
                end
                if (rHs) begin
                    bus.iRVALID = 0; arDone = 0; rCnt = 0;
                end
                if (pAwV && !awHs) begin
                    chk("awvalid hold", bus.oAWVALID, 1);
                    chk("awaddr stable", bus.oAWADDR, pAwAddr);
                end
                if (pWV && !wHs) begin
                    chk("wvalid hold", bus.oWVALID, 1);
                    chk("wdata stable", bus.oWDATA, pWData);
                end
                if (pArV && !arHs) begin
                    chk("arvalid hold", bus.oARVALID, 1);
                    chk("araddr stable", bus.oARADDR, pArAddr);
                end
                if (awHs) chk("awvalid drop", bus.oAWVALID, 0);
                if (wHs) chk("wvalid drop", bus.oWVALID, 0);
                if (arHs) chk("arvalid drop", bus.oARVALID, 0);
                if (bus.oBREADY) chk("bready after aw+w", awDone && wDone, 1);
                if (bus.oAWVALID) begin
                    bus.iAWREADY = (awCnt >= awDly); awCnt++;
                end else begin
                    bus.iAWREADY = 0; awCnt = 0;
                end
                if (bus.oWVALID) begin
                    bus.iWREADY = (wCnt >= wDly); wCnt++;
                end else begin
                    bus.iWREADY = 0; wCnt = 0;
                end
                if (bus.oARVALID) begin
                    bus.iARREADY = (arCnt >= arDly); arCnt++;
                end else begin
                    bus.iARREADY = 0; arCnt = 0;
                end
                if (awDone && wDone && !bus.iBVALID) begin
                    if (bCnt >= bDly) begin
                        bus.iBVALID = 1; bus.iBRESP = sResp;
                    end else bCnt++;
                end
                if (arDone && !bus.iRVALID) begin
                    if (rCnt >= rDly) begin
                        bus.iRVALID = 1; bus.iRRESP = sResp; bus.iRDATA = sData;
                    end else rCnt++;
                end
                awHs = bus.oAWVALID && bus.iAWREADY;
                wHs  = bus.oWVALID && bus.iWREADY;
                arHs = bus.oARVALID && bus.iARREADY;
                bHs  = bus.iBVALID && bus.oBREADY;
                rHs  = bus.iRVALID && bus.oRREADY;
                if (awHs) awCap = bus.oAWADDR;
                if (wHs) begin wCap = bus.oWDATA; strbCap = bus.oWSTRB; end
                if (arHs) begin arCap = bus.oARADDR; arCycles = arCnt; end
                pAwV = bus.oAWVALID; pAwAddr = bus.oAWADDR;
                pWV  = bus.oWVALID;  pWData  = bus.oWDATA;
                pArV = bus.oARVALID; pArAddr = bus.oARADDR;
            end
        end
    end

    // host side: one command, response held rspDly cycles
    task automatic runTxn(input vecT v, input string nm, output int toutAt);
        int acc, lat;
        logic ok, seen;
        sData = v.sdat; sResp = v.sresp;
        if (v.wr) begin awDly = v.d0; wDly = v.d1; bDly = v.d2; end
        else begin arDly = v.d0; rDly = v.d2; end
        cmdValid = 1; cmdWr = v.wr; cmdAdr = v.adr;
        cmdWdat = v.wdat; cmdStrb = v.strb;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmdReady) ok = 1;
        end
        chk({nm, " accept"}, ok, 1);
        @(posedge clk); #1;
        cmdValid = 0;
        acc = cyc; seen = 0; lat = -1; toutAt = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (tout && toutAt < 0) toutAt = cyc - acc;
            if (rspValid) begin seen = 1; lat = cyc - acc; end
        end
        chk({nm, " latency"}, lat, v.expLat);
        for (int k = 0; k <= v.rspDly; k++) begin
            chk({nm, " rspvalid"}, rspValid, 1);
            chk({nm, " rspwr"}, rspWr, v.wr);
            chk({nm, " rdat"}, rspRdat, v.expRdat);
            chk({nm, " resp"}, rspResp, v.expResp);
            chk({nm, " no accept"}, cmdReady, 0);
            if (k == v.rspDly) rspReady = 1;
            @(posedge clk); #1;
            rspReady = 0;
            if (k < v.rspDly) @(negedge clk);
        end
        if (v.wr) begin
            chk({nm, " awaddr"}, awCap, v.expAdr);
            chk({nm, " wdata"}, wCap, v.wdat);
            chk({nm, " wstrb"}, strbCap, v.strb);
        end else begin
            chk({nm, " araddr"}, arCap, v.expAdr);
            chk({nm, " ar cycles"}, arCycles, v.d0 + 1);
        end
    endtask

    initial begin
        vecT vt[6];
        vecT r;
        int ta;
        rst = 1; cmdValid = 0; rspReady = 0;
        cmdWr = 0; cmdAdr = 0; cmdWdat = 0; cmdStrb = 0;
        awDly = 0; wDly = 0; bDly = 0; arDly = 0; rDly = 0;
        sData = 0; sResp = OKAY;
        vt[0] = '{wr:1, adr:32'h10, wdat:32'hDEADBEEF, strb:4'hF, sdat:0,
                  sresp:OKAY, d0:0, d1:0, d2:0, rspDly:0, expAdr:32'h10,
                  expRdat:0, expResp:OKAY, expLat:2};
        vt[1] = '{wr:0, adr:32'h14, wdat:0, strb:0, sdat:32'h12345678,
                  sresp:OKAY, d0:2, d1:0, d2:0, rspDly:0, expAdr:32'h14,
                  expRdat:32'h12345678, expResp:OKAY, expLat:4};
        vt[2] = '{wr:1, adr:32'h40, wdat:32'hA5A50001, strb:4'h3, sdat:0,
                  sresp:EXOKAY, d0:4, d1:2, d2:0, rspDly:1, expAdr:32'h40,
                  expRdat:0, expResp:EXOKAY, expLat:6};
        vt[3] = '{wr:1, adr:32'h23, wdat:32'h0F0FF0F0, strb:4'h5, sdat:0,
                  sresp:OKAY, d0:2, d1:4, d2:1, rspDly:0, expAdr:32'h20,
                  expRdat:0, expResp:OKAY, expLat:7};
        vt[4] = '{wr:0, adr:32'h8, wdat:0, strb:0, sdat:32'hCAFE0001,
                  sresp:SLVERR, d0:0, d1:0, d2:1, rspDly:5, expAdr:32'h8,
                  expRdat:32'hCAFE0001, expResp:SLVERR, expLat:3};
        vt[5] = '{wr:1, adr:32'h1001, wdat:32'h1, strb:4'h8, sdat:0,
                  sresp:DECERR, d0:0, d1:0, d2:2, rspDly:2, expAdr:32'h1000,
                  expRdat:0, expResp:DECERR, expLat:4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cmdready", cmdReady, 0);
        chk("reset valids", {bus.oAWVALID, bus.oWVALID, bus.oARVALID,
            bus.oBREADY, bus.oRREADY, rspValid}, 0);
        chk("reset tout", tout, 0);
        chk("reset addr", bus.oAWADDR, 0);
        chk("reset rdat", rspRdat, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("idle cmdready", cmdReady, 1);
        chk("prot", {bus.oAWPROT, bus.oARPROT}, 6'b101101);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            runTxn(vt[i], $sformatf("vec%0d", i), ta);
        end

        for (int i = 0; i < 30; i++) begin
            r.wr = 1'($urandom % 2);
            r.adr = $urandom; r.wdat = $urandom; r.sdat = $urandom;
            r.strb = 4'($urandom % 16); r.sresp = 2'($urandom % 4);
            r.d0 = $urandom_range(0, 2); r.d1 = $urandom_range(0, 2);
            r.d2 = $urandom_range(0, 2); r.rspDly = $urandom_range(0, 3);
            r.expAdr = r.adr & ~32'h3;
            r.expRdat = r.wr ? 32'h0 : r.sdat;
            r.expResp = r.sresp;
            r.expLat = 2 + r.d2 + (r.wr ? ((r.d0 > r.d1) ? r.d0 : r.d1) : r.d0);
            runTxn(r, $sformatf("rnd%0d", i), ta);
        end
        chk("tout clear before wdog", tout, 0);

        r = '{wr:1, adr:32'h80, wdat:32'h5555AAAA, strb:4'hF, sdat:0,
              sresp:OKAY, d0:0, d1:0, d2:20, rspDly:0, expAdr:32'h80,
              expRdat:0, expResp:OKAY, expLat:22};
        runTxn(r, "wdog", ta);
        chk("wdog edge", ta, 8);
        @(negedge clk);
        chk("wdog sticky", tout, 1);
        @(posedge clk); #1;

        arDly = 50; rDly = 0;
        cmdValid = 1; cmdWr = 0; cmdAdr = 32'h3;
        begin
            logic ok;
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (cmdReady) ok = 1;
            end
            chk("rst txn accept", ok, 1);
        end
        @(posedge clk); #1;
        cmdValid = 0;
        @(negedge clk);
        chk("rst txn arvalid", bus.oARVALID, 1);
        chk("rst txn araddr", bus.oARADDR, 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rst cmdready", cmdReady, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst drop valids", {bus.oAWVALID, bus.oWVALID, bus.oARVALID,
            bus.oBREADY, bus.oRREADY, rspValid}, 0);
        chk("rst tout", tout, 0);
        @(posedge clk); #1;
        r = '{wr:0, adr:32'h3, wdat:0, strb:0, sdat:32'h0BADF00D,
              sresp:OKAY, d0:0, d1:0, d2:0, rspDly:0, expAdr:32'h0,
              expRdat:32'h0BADF00D, expResp:OKAY, expLat:2};
        runTxn(r, "post rst read", ta);
        chk("post rst tout", tout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
